// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX byte queue.
//   UART_DATA_W : default byte width, must match the UART txin width
//   txq_state_t : TX queue FSM state encoding
package uart_pkg;
  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    TXQ_IDLE,
    TXQ_LOAD,
    TXQ_BUSY,
    TXQ_GAP
  } txq_state_t;
endpackage

// File: rtl/uart_tx_queue_fifo.sv
// sync_fifo: single-clock FIFO with a registered read port.
//   clk, rst      : clock, async active-high reset (pointers/count cleared)
//   wr_en/wr_data : write request; ignored while full
//   rd_en/rd_data : read request; rd_data is valid the cycle after rd_en
//   full/empty    : occupancy flags
//   count         : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              do_wr, do_rd;

  // A write while full is dropped even if a read happens on the same edge.
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // Storage has no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
      count   <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte queue feeding the UART TX start/txin pair.
//   clk, rst  : clock, async active-high reset
//   in_valid/in_data/in_ready : host byte handshake (in_ready = !full)
//   start     : one-cycle pulse to the UART, coincident with the new txin
//   txin      : byte to the UART, held until the next frame is loaded
//   txdone    : UART frame-complete strobe (only honoured while BUSY)
//   busy      : FSM not idle
//   empty     : FIFO holds no bytes
// Optional feature macro UART_TXQ_STATUS_EN adds:
//   level     : current FIFO occupancy
//   ovf       : sticky flag, set on a write attempted while full
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_W     = UART_DATA_W,
  parameter int GAP_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic                   start,
  output logic [DATA_W-1:0]      txin,
  input  logic                   txdone,
  output logic                   busy,
  output logic                   empty
`ifdef UART_TXQ_STATUS_EN
  ,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf
`endif
);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  txq_state_t             state, state_nx;
  logic [GW-1:0]          gap_cnt;
  logic                   pop;
  logic                   fifo_full, fifo_empty;
  logic [DATA_W-1:0]      fifo_rd;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [DATA_W-1:0]      txin_q;
  logic                   start_q;

  sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_valid),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign in_ready = !fifo_full;
  assign empty    = fifo_empty;
  assign busy     = (state != TXQ_IDLE);
  assign start    = start_q;
  assign txin     = txin_q;

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    unique case (state)
      TXQ_IDLE: if (!fifo_empty) begin
        pop      = 1'b1;
        state_nx = TXQ_LOAD;
      end
      TXQ_LOAD: state_nx = TXQ_BUSY;
      TXQ_BUSY: if (txdone) state_nx = TXQ_GAP;
      TXQ_GAP:  if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nx = TXQ_IDLE;
      default:  state_nx = TXQ_IDLE;
    endcase
  end

  // The FIFO read data lands during LOAD; txin and start are registered
  // together on the LOAD->BUSY edge so the UART sees the byte and the
  // strobe in the same cycle (two cycles after the push edge).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= TXQ_IDLE;
      gap_cnt <= '0;
      txin_q  <= '0;
      start_q <= 1'b0;
    end else begin
      state   <= state_nx;
      start_q <= (state == TXQ_LOAD);
      if (state == TXQ_LOAD) txin_q <= fifo_rd;
      if (state == TXQ_BUSY && txdone) gap_cnt <= '0;
      else if (state == TXQ_GAP)       gap_cnt <= gap_cnt + 1'b1;
    end
  end

`ifdef UART_TXQ_STATUS_EN
  assign level = fifo_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        ovf <= 1'b0;
    else if (in_valid && !in_ready) ovf <= 1'b1;
  end
`else
  logic unused_count;
  assign unused_count = ^fifo_count;
`endif
endmodule
